fir_decim_pipe: RTL and testbench
=================================

# fir_decim_pipe

Polyphase decimating FIR filter: the receive-side counterpart of the interpolation filter. It accepts one input sample per handshake, keeps a delay line of the last NUM_TAPS samples, and every DECIM_FACTOR accepted samples computes one filtered output with a single time-multiplexed multiply-accumulate over NUM_TAPS cycles. It sits after the decimation point of the signal chain and trades throughput for area: one multiplier instead of NUM_TAPS.

## Interface
- DATA_WIDTH, 8: signed sample width, input and output.
- TAP_COEFF_WIDTH, 8: signed coefficient width, Q1.(TAP_COEFF_WIDTH-1).
- NUM_TAPS, 16: filter length, 2 or more.
- DECIM_FACTOR, 4: decimation ratio M, 2 or more.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in  in  DATA_WIDTH  signed input sample.
- in_valid  in  1  in carries a sample.
- in_ready  out  1  block can accept; transfer on in_valid && in_ready at the clock edge.
- tap_coeffs  in  TAP_COEFF_WIDTH x NUM_TAPS  signed coefficients, unpacked array, index k multiplies x[n-k].
- out  out  DATA_WIDTH  signed decimated output, registered.
- out_valid  out  1  one-cycle pulse, out is new; no backpressure.

## Operation
- Delay line dl[0..NUM_TAPS-1]. On each accepted sample, dl[0] takes in and dl[k] takes dl[k-1].
- Phase counter 0..DECIM_FACTOR-1, incremented on each accept and wrapping to 0 after DECIM_FACTOR-1.
- Frame edge: an accept while the phase is DECIM_FACTOR-1. On the same edge, snapshot the post-shift delay line and all tap_coeffs into snap/csnap. Coefficient changes after the snapshot do not affect that output.
- FSM:
  - IDLE: wait for a frame edge, then go to MAC with k=0 and acc=0.
  - MAC: acc += snap[k]*csnap[k] and k++ on each edge. After the k=NUM_TAPS-1 edge, go to OUT.
  - OUT: out <= sat(acc >>> (TAP_COEFF_WIDTH-1)) and out_valid <= 1. Go to MAC if a frame edge occurs on this edge, otherwise IDLE.
- in_ready = (phase != DECIM_FACTOR-1) || state is IDLE or OUT. Non-frame samples are accepted during MAC.
- Arithmetic:
  - Product width is DATA_WIDTH+TAP_COEFF_WIDTH.
  - acc width is DATA_WIDTH+TAP_COEFF_WIDTH+$clog2(NUM_TAPS) and never overflows.
  - Shift is arithmetic.
  - Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].

## Timing
- Reset values:
  - out=0, out_valid=0.
  - Phase 0, state IDLE.
  - dl, snap, csnap, acc and k all 0.
  - in_ready=1 during and after reset.
- Latency:
  - Frame edge E0.
  - MAC edges E1..E_NUM_TAPS.
  - out/out_valid updated at E_NUM_TAPS+1, i.e. NUM_TAPS+1 edges after the frame edge.
- Sustained rate: if DECIM_FACTOR >= NUM_TAPS+1, in_ready stays 1 under continuous in_valid. Otherwise in_ready drops only at phase DECIM_FACTOR-1 until OUT.
- A frame edge coinciding with OUT is legal. The output is emitted and the next MAC starts on the same edge.
- Reset mid-MAC aborts the computation: no out_valid, and all state returns to reset values.
- out holds its value between pulses.

## Configuration
- FIR_DECIM_ROUND_EN defined: add 2^(TAP_COEFF_WIDTH-2) to acc before the shift (round half up).
- Not defined: plain truncation, i.e. arithmetic shift only.
- No other behaviour differs.

## Structure
- Package fir_pkg holds:
  - typedef fir_decim_state_t {IDLE, MAC, OUT};
  - function sat_trunc(value, width) for shift-and-clamp;
  - constant ACC_GUARD = $clog2(NUM_TAPS) helper.
- One sub-module, mac_sat: a registered multiply-accumulate with clear, enable and the final shift/round/saturate. It is reused by later filters.

## Test plan
All scenarios use DATA_WIDTH=8, TAP_COEFF_WIDTH=8, NUM_TAPS=4, DECIM_FACTOR=2 and coeffs [64,32,16,8], unless noted.

- **Impulse:** samples 0,100,0,0,0,0 with in_valid continuous.
  - Outputs are 50, then 12 (truncate) or 13 (FIR_DECIM_ROUND_EN), then 0.
  - Each out_valid comes 5 edges after its frame edge.
- **Positive saturation:** coeffs all 127, inputs all 127. Steady-state out = 127 (raw 504).
- **Negative saturation:** coeffs all 127, inputs all -128. Steady-state out = -128 (raw -508).
- **Backpressure:** continuous in_valid with 20 samples.
  - in_ready is low at phase 1 while MAC is busy.
  - No sample is dropped or duplicated; exactly 10 out_valid pulses.
  - A reference model matches every output.
- **Coefficient change mid-MAC:** change tap_coeffs to all 0 two edges after the frame edge. The current output is still computed with the old coeffs; the next frame yields 0.
- **Reset mid-MAC:** assert rst at MAC edge E2.
  - out=0, out_valid=0 and in_ready=1 immediately.
  - No pulse appears afterwards.
  - After release, the impulse test reproduces the same results.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the decimating FIR family.
// Rounding option is selected in mac_sat by FIR_DECIM_ROUND_EN.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_decim_state_t;

  localparam int SAT_W = 64;
  localparam int DEFAULT_NUM_TAPS = 16;
  localparam int ACC_GUARD = $clog2(DEFAULT_NUM_TAPS);

  // Guard bits needed so a sum of num_taps full-scale products cannot overflow.
  function automatic int acc_guard(input int num_taps);
    return $clog2(num_taps);
  endfunction

  // Clamp an already-shifted value to the signed range of 'width' bits.
  function automatic logic signed [SAT_W-1:0] sat_trunc(
    input logic signed [SAT_W-1:0] value,
    input int                      width
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = ~hi;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/fir_decim_pipe_mac_sat.sv
// Registered multiply-accumulate with clear/enable and a shift/round/saturate result.
// FIR_DECIM_ROUND_EN adds half an output LSB before the shift (round half up).
module mac_sat
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int ACC_WIDTH   = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          en,
  input  logic signed [DATA_WIDTH-1:0]  sample,
  input  logic signed [COEFF_WIDTH-1:0] coeff,
  output logic signed [DATA_WIDTH-1:0]  result
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;

  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc_reg;
  logic signed [ACC_WIDTH-1:0]  biased;
  logic signed [ACC_WIDTH-1:0]  shifted;

  assign prod = PROD_WIDTH'(sample) * PROD_WIDTH'(coeff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + ACC_WIDTH'(prod);
    end
  end

`ifdef FIR_DECIM_ROUND_EN
  localparam logic signed [ACC_WIDTH-1:0] HALF_LSB = ACC_WIDTH'(1) << (COEFF_WIDTH - 2);
  assign biased = acc_reg + HALF_LSB;
`else
  assign biased = acc_reg;
`endif

  // Coefficients are Q1.(COEFF_WIDTH-1), so dropping COEFF_WIDTH-1 bits restores sample scale.
  assign shifted = biased >>> (COEFF_WIDTH - 1);
  assign result  = DATA_WIDTH'(sat_trunc(SAT_W'(shifted), DATA_WIDTH));

endmodule

// File: rtl/fir_decim_pipe.sv
// Polyphase decimating FIR: one output per DECIM_FACTOR inputs, one shared MAC over NUM_TAPS cycles.
// Optional FIR_DECIM_ROUND_EN selects round-half-up instead of truncation (inside mac_sat).
module fir_decim_pipe
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int TAP_COEFF_WIDTH = 8,
  parameter int NUM_TAPS        = 16,
  parameter int DECIM_FACTOR    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [DATA_WIDTH-1:0]      in,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS],
  output logic signed [DATA_WIDTH-1:0]      out,
  output logic                              out_valid
);

  localparam int ACC_WIDTH = DATA_WIDTH + TAP_COEFF_WIDTH + acc_guard(NUM_TAPS);
  localparam int PHASE_W   = $clog2(DECIM_FACTOR);
  localparam int K_W       = $clog2(NUM_TAPS);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DECIM_FACTOR - 1);
  localparam logic [K_W-1:0]     LAST_K     = K_W'(NUM_TAPS - 1);

  fir_decim_state_t state_reg;
  logic [PHASE_W-1:0] phase_reg;
  logic [K_W-1:0]     k_reg;

  logic signed [DATA_WIDTH-1:0]      dl_reg    [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]      dl_next   [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]      snap_reg  [NUM_TAPS];
  logic signed [TAP_COEFF_WIDTH-1:0] csnap_reg [NUM_TAPS];

  logic accept;
  logic frame;
  logic signed [DATA_WIDTH-1:0] mac_result;

  // Frame samples stall while the MAC is busy; all other phases flow through.
  assign in_ready = (phase_reg != LAST_PHASE) || (state_reg == IDLE) || (state_reg == OUT);
  assign accept   = in_valid && in_ready;
  assign frame    = accept && (phase_reg == LAST_PHASE);

  // Post-shift view of the delay line; the snapshot needs it on the frame edge.
  generate
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_shift
      if (gi == 0) begin : g_head
        assign dl_next[gi] = in;
      end else begin : g_tail
        assign dl_next[gi] = dl_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        dl_reg[i]    <= '0;
        snap_reg[i]  <= '0;
        csnap_reg[i] <= '0;
      end
    end else if (accept) begin
      phase_reg <= (phase_reg == LAST_PHASE) ? '0 : phase_reg + PHASE_W'(1);
      for (int i = 0; i < NUM_TAPS; i++) begin
        dl_reg[i] <= dl_next[i];
      end
      if (frame) begin
        for (int i = 0; i < NUM_TAPS; i++) begin
          snap_reg[i]  <= dl_next[i];
          csnap_reg[i] <= tap_coeffs[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (frame) begin
            state_reg <= MAC;
            k_reg     <= '0;
          end
        end
        MAC: begin
          if (k_reg == LAST_K) begin
            state_reg <= OUT;
            k_reg     <= '0;
          end else begin
            k_reg <= k_reg + K_W'(1);
          end
        end
        OUT: begin
          out       <= mac_result;
          out_valid <= 1'b1;
          k_reg     <= '0;
          state_reg <= frame ? MAC : IDLE;
        end
        default: begin
          state_reg <= IDLE;
          k_reg     <= '0;
        end
      endcase
    end
  end

  // The accumulator clears on every frame edge, including one that lands on OUT.
  mac_sat #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COEFF_WIDTH (TAP_COEFF_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (frame),
    .en     (state_reg == MAC),
    .sample (snap_reg[k_reg]),
    .coeff  (csnap_reg[k_reg]),
    .result (mac_result)
  );

endmodule

// File: tb/tb_fir_decim_pipe.sv
// Scoreboard bench for fir_decim_pipe with NUM_TAPS=4, DECIM_FACTOR=2.
// Honors FIR_DECIM_ROUND_EN for its expected values.
module tb_fir_decim_pipe;

`ifdef FIR_DECIM_ROUND_EN
  localparam int IMP_SECOND = 13;
  localparam int CC_FIRST   = 43;
  localparam longint RND    = 64;
`else
  localparam int IMP_SECOND = 12;
  localparam int CC_FIRST   = 42;
  localparam longint RND    = 0;
`endif

  logic clk;
  logic rst;
  logic signed [7:0] din;
  logic in_valid;
  logic in_ready;
  logic signed [7:0] coeffs [4];
  logic signed [7:0] out;
  logic out_valid;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int saw_low = 0;
  int last_out = 0;
  int m_dl [4];
  int m_phase = 0;
  int exp_q [$];
  int frm_q [$];
  int got_q [$];

  fir_decim_pipe #(
    .DATA_WIDTH(8), .TAP_COEFF_WIDTH(8), .NUM_TAPS(4), .DECIM_FACTOR(2)
  ) dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .tap_coeffs(coeffs), .out(out), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: delay line, phase and expected output at each frame edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) m_dl[k] = 0;
      m_phase = 0;
      exp_q.delete();
      frm_q.delete();
    end else begin
      cyc++;
      if (in_valid && in_ready) begin
        for (int k = 3; k > 0; k--) m_dl[k] = m_dl[k-1];
        m_dl[0] = din;
        if (m_phase == 1) begin
          longint a;
          a = 0;
          for (int k = 0; k < 4; k++) a += longint'(m_dl[k]) * longint'(coeffs[k]);
          a = (a + RND) >>> 7;
          if (a > 127) a = 127;
          if (a < -128) a = -128;
          exp_q.push_back(int'(a));
          frm_q.push_back(cyc);
          m_phase = 0;
        end else begin
          m_phase = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      last_out = 0;
    end else begin
      if (!in_ready) saw_low = 1;
      if (out_valid) begin
        pulses++;
        got_q.push_back(int'(out));
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          int e;
          int f;
          e = exp_q.pop_front();
          f = frm_q.pop_front();
          $display("out=%0d expected=%0d latency=%0d", out, e, cyc - f);
          chk("out_value", out, e);
          chk("latency", cyc - f, 5);
        end
        last_out = int'(out);
      end else begin
        chk("out_hold", out, last_out);
      end
    end
  end

  task automatic send(input logic signed [7:0] s);
    int w;
    w = 0;
    din = s;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic drain();
    int w;
    w = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_coeffs(input int c0, input int c1, input int c2, input int c3);
    coeffs[0] = 8'(c0);
    coeffs[1] = 8'(c1);
    coeffs[2] = 8'(c2);
    coeffs[3] = 8'(c3);
  endtask

  task automatic run_impulse(input string tag);
    set_coeffs(64, 32, 16, 8);
    got_q.delete();
    send(0); send(100); send(0); send(0); send(0); send(0);
    drain();
    chk({tag, "_count"}, got_q.size(), 3);
    chk({tag, "_first"}, (got_q.size() > 0) ? got_q[0] : 999, 50);
    chk({tag, "_second"}, (got_q.size() > 1) ? got_q[1] : 999, IMP_SECOND);
    chk({tag, "_third"}, (got_q.size() > 2) ? got_q[2] : 999, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst = 1'b1;
    din = '0;
    in_valid = 1'b0;
    set_coeffs(64, 32, 16, 8);
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    run_impulse("impulse");

    // Positive saturation
    do_reset();
    set_coeffs(127, 127, 127, 127);
    got_q.delete();
    repeat (8) send(127);
    drain();
    chk("pos_sat", (got_q.size() > 0) ? got_q[$] : 999, 127);

    // Reset mid-MAC, starting from out=127
    set_coeffs(64, 32, 16, 8);
    p0 = pulses;
    send(0);
    send(100);
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out", out, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_no_pulse", pulses - p0, 0);
    run_impulse("impulse_after_rst");

    // Negative saturation
    do_reset();
    set_coeffs(127, 127, 127, 127);
    got_q.delete();
    repeat (8) send(-128);
    drain();
    chk("neg_sat", (got_q.size() > 0) ? got_q[$] : 999, -128);

    // Backpressure with random data
    do_reset();
    set_coeffs(64, 32, 16, 8);
    p0 = pulses;
    saw_low = 0;
    for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)));
    drain();
    chk("bp_pulses", pulses - p0, 10);
    chk("bp_ready_low", saw_low, 1);

    // Coefficient change mid-MAC
    do_reset();
    set_coeffs(64, 32, 16, 8);
    got_q.delete();
    send(50);
    send(60);
    in_valid = 1'b0;
    @(negedge clk);
    set_coeffs(0, 0, 0, 0);
    send(0);
    send(0);
    drain();
    chk("cc_first", (got_q.size() > 0) ? got_q[0] : 999, CC_FIRST);
    chk("cc_second", (got_q.size() > 1) ? got_q[1] : 999, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
